led_ctrl: RTL
=============

# led_ctrl

Memory-mapped LED controller between the CPU data-memory bus and the `io_leds` pad block. It holds the LED data, brightness and control registers, and applies per-frame PWM dimming and an optional heartbeat on LED7. It sequences pad shutdown around WFI so the pads tri-state only at a PWM frame boundary with the bus low, and re-enable cleanly on wake. Its `pad_sleep` output drives the `wfi` input of `io_leds`.

## Interface
- `PWM_BITS`, 4: width of PWM counter and brightness field; frame = 2^PWM_BITS cycles.
- `HB_DIV`, 24: heartbeat counter width; LED7 heartbeat period = 2^HB_DIV cycles, 50% duty.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_we`  in  1  register write strobe, one cycle per write.
- `cpu_addr`  in  2  register select.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  combinational read data for `cpu_addr`.
- `wfi`  in  1  CPU wait-for-interrupt level.
- `led_bus`  out  8  registered LED drive to `io_leds.led_bus`.
- `pad_sleep`  out  1  registered; 1 = pads high-Z. Connects to `io_leds.wfi`.

## Operation
- Registers:
  - addr0 LED_DATA[7:0], R/W.
  - addr1 BRIGHT[PWM_BITS-1:0], R/W, upper bits read 0.
  - addr2 CTRL, R/W: bit0 HB_EN, bit1 BLANK, others read 0.
  - addr3 STATUS, RO: {5'b0, state[1:0], hb}. Writes to addr3 are ignored.
- Writes are accepted in every FSM state.
- PWM:
  - `pwm_cnt` increments every cycle in RUN and DRAIN, wrapping from 2^PWM_BITS-1 to 0.
  - `pwm_on` = (BRIGHT == all-ones) | (pwm_cnt < BRIGHT).
  - BRIGHT=0 gives always off; all-ones gives always on.
- Heartbeat: `hb_cnt` (HB_DIV bits) increments every cycle except in SLEEP, where it holds. `hb` = MSB of `hb_cnt`.
- Next `led_bus`:
  - Base: LED_DATA & {8{pwm_on}}.
  - If HB_EN, bit7 = hb, not gated by PWM.
  - If BLANK, or state is SLEEP or WAKE, all bits = 0.
- FSM, encoding RUN=0, DRAIN=1, SLEEP=2, WAKE=3:
  - RUN: `wfi` → DRAIN.
  - DRAIN: `!wfi` → RUN (abort, no glitch). Else if pwm_cnt == max → SLEEP.
  - SLEEP: `pad_sleep` = 1, `pwm_cnt` held at 0, `led_bus` = 0. `!wfi` → WAKE.
  - WAKE: `pad_sleep` = 0, `led_bus` = 0, `pwm_cnt` = 0. → RUN unconditionally next cycle.
  - In DRAIN, if `wfi` drops on the same cycle pwm_cnt == max, abort wins: go to RUN.
- Reset values:
  - LED_DATA = 0, BRIGHT = all-ones, CTRL = 0.
  - state = RUN, `pwm_cnt` = 0, `hb_cnt` = 0.
  - `led_bus` = 0, `pad_sleep` = 0.
- Reset from any state, including SLEEP, returns to RUN with `pad_sleep` = 0 on the next edge.

## Timing
- Write latency:
  - Edge k: `cpu_we` is sampled and the register updates.
  - Edge k+1: `led_bus` reflects the new value, given RUN/DRAIN and `pwm_on`.
- `cpu_rdata` is combinational from the current register contents; same-cycle read-after-write returns the old value.
- Sleep entry:
  - Edge e: the SLEEP transition occurs, on the pwm_cnt==max cycle.
  - On that same edge, `led_bus` <= 0 and `pad_sleep` <= 1.
  - Worst case from `wfi` rise: 2^PWM_BITS + 1 edges.
- Wake:
  - `wfi` low is sampled at edge w: state = WAKE, `pad_sleep` = 0, `led_bus` = 0.
  - Edge w+1: RUN.
  - Edge w+2: first driven value; `pwm_cnt` = 1 at that point.
- Pads are never tri-stated while `led_bus` ≠ 0.
- Pads are never re-driven without one cycle of `led_bus` = 0 beforehand.

## Test plan
- Reset, then write addr0=0xA5 with BRIGHT default → `led_bus` = 0xA5 two edges after the write; `pad_sleep` = 0; readback of addr0 = 0xA5, addr1 = 0x0F.
- BRIGHT=4, LED_DATA=0xFF → `led_bus` = 0xFF for exactly 4 of every 16 cycles, 0x00 for 12; BRIGHT=0 → always 0.
- HB_EN=1, `HB_DIV`=4, LED_DATA=0 → bit7 toggles every 8 cycles; BLANK=1 → `led_bus` = 0 regardless.
- Raise `wfi` mid-frame (pwm_cnt=5) → STATUS state=1 until pwm_cnt=15, then `pad_sleep`=1 and `led_bus`=0 on the same edge; STATUS state=2; `hb_cnt` frozen.
- Drop `wfi` in SLEEP → one WAKE cycle (`pad_sleep`=0, `led_bus`=0), then RUN with PWM restarted from 0. Separately, drop `wfi` in DRAIN → RUN with `pad_sleep` never asserted.
- Assert `rst` in SLEEP with a write pending → next edge: RUN, `pad_sleep`=0, `led_bus`=0, all registers at reset values; the write is discarded.

Source files
------------

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: data/brightness/control registers, per-frame PWM, LED7 heartbeat and WFI pad sequencing.
// led_bus and pad_sleep are registered (one edge after a register write); no backpressure, writes accepted every cycle.
module led_ctrl #(
    parameter int PWM_BITS = 4,
    parameter int HB_DIV   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    input  logic       wfi,
    output logic [7:0] led_bus,
    output logic       pad_sleep
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          led_data;
    logic [PWM_BITS-1:0] bright;
    logic                hb_en;
    logic                blank;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_nxt;
    logic [HB_DIV-1:0]   hb_cnt;
    logic                hb;
    logic                pwm_on;
    logic [7:0]          led_nxt;

    assign hb     = hb_cnt[HB_DIV-1];
    assign pwm_on = (bright == PWM_MAX) | (pwm_cnt < bright);

    always_comb begin
        cpu_rdata = 8'h00;
        case (cpu_addr)
            2'd0:    cpu_rdata = led_data;
            2'd1:    cpu_rdata = 8'(bright);
            2'd2:    cpu_rdata = {6'b0, blank, hb_en};
            default: cpu_rdata = {5'b0, state, hb};
        endcase
    end

    // Abort in DRAIN takes priority over the frame-end sleep entry.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (wfi) state_nxt = DRAIN;
            DRAIN: begin
                if (!wfi)                    state_nxt = RUN;
                else if (pwm_cnt == PWM_MAX) state_nxt = SLEEP;
            end
            SLEEP:   if (!wfi) state_nxt = WAKE;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pwm_nxt = '0;
        if (state == RUN || state == DRAIN) pwm_nxt = pwm_cnt + 1'b1;
    end

    // Gating on both current and next state keeps the bus low on the sleep
    // entry edge and for the whole WAKE->RUN handover.
    always_comb begin
        led_nxt = led_data & {8{pwm_on}};
        if (hb_en) led_nxt[7] = hb;
        if (blank || state == SLEEP || state == WAKE ||
            state_nxt == SLEEP || state_nxt == WAKE)
            led_nxt = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            led_data  <= 8'h00;
            bright    <= PWM_MAX;
            hb_en     <= 1'b0;
            blank     <= 1'b0;
            pwm_cnt   <= '0;
            hb_cnt    <= '0;
            led_bus   <= 8'h00;
            pad_sleep <= 1'b0;
        end else begin
            state     <= state_nxt;
            pwm_cnt   <= pwm_nxt;
            led_bus   <= led_nxt;
            pad_sleep <= (state_nxt == SLEEP);
            if (state != SLEEP) hb_cnt <= hb_cnt + 1'b1;
            if (cpu_we) begin
                case (cpu_addr)
                    2'd0: led_data <= cpu_wdata;
                    2'd1: bright   <= cpu_wdata[PWM_BITS-1:0];
                    2'd2: begin
                        hb_en <= cpu_wdata[0];
                        blank <= cpu_wdata[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
